// File: rtl/apb_mem_slave.sv
// APB4 memory-backed slave: byte-strobed writes, fixed wait states, address
// decode errors, and outputs decoded purely from registered state.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;

  generate
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_width
      $error("apb_mem_slave: DATA_WIDTH must be 8, 16 or 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("apb_mem_slave: WAIT_STATES must be in 0..15");
    end
  endgenerate

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               capture;
  logic               commit;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] off_mask;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  addr_err;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd;

  logic                  write_p1;
  logic                  err_p1;
  logic [IDX_W-1:0]      idx_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;

  // Address decode, evaluated on the live bus during the setup phase.
  assign word_idx     = PADDR >> OFF_W;
  assign off_mask     = ADDR_WIDTH'(NB - 1);
  assign misaligned   = |(PADDR & off_mask);
  assign out_of_range = {1'b0, word_idx} >= (ADDR_WIDTH + 1)'(DEPTH);
  assign addr_err     = misaligned | out_of_range;
  assign mem_rd       = mem[word_idx[IDX_W-1:0]];

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
          capture = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
            commit  = write_p1 & ~err_p1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Setup -> access boundary: freeze direction, index, error and read data.
  always_ff @(posedge PCLK) begin
    if (capture) begin
      write_p1 <= PWRITE;
      err_p1   <= addr_err;
      idx_p1   <= word_idx[IDX_W-1:0];
      rdata_p1 <= addr_err ? '0 : mem_rd;
    end
  end

  // Completion edge: per-lane commit using the data on the bus at that edge.
  always_ff @(posedge PCLK) begin
    if (commit) begin
      for (int i = 0; i < NB; i++) begin
        if (PSTRB[i]) begin
          mem[idx_p1][8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

  assign PREADY  = (state_q == ACCESS) && (cnt_q == '0);
  assign PSLVERR = PREADY & err_p1;
  assign PRDATA  = (PREADY && !write_p1) ? rdata_p1 : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 3 and 5 wait states) driven by a
// transfer-level master and checked every cycle against a memory/timing model.
module tb_apb_mem_slave;

  localparam int NI = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn    [NI];
  logic        psel    [NI];
  logic        penable [NI];
  logic        pwrite  [NI];
  logic [11:0] paddr   [NI];
  logic [31:0] pwdata  [NI];
  logic [3:0]  pstrb   [NI];
  logic        pready  [NI];
  logic        pslverr [NI];
  logic [31:0] prdata  [NI];

  logic        exp_rdy  [NI];
  logic        exp_err  [NI];
  logic [31:0] exp_data [NI];
  logic [31:0] exp_mask [NI];

  logic [31:0] mm [NI][256];
  logic [3:0]  kn [NI][256];

  int total = 0;
  int bad   = 0;

  apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESET(rstn[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESET(rstn[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(5)) u_ws5 (
    .PCLK(clk), .PRESET(rstn[2]), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  function automatic int wsf(input int n);
    return (n == 0) ? 0 : (n == 1) ? 3 : 5;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  // Per-cycle comparison of every instance against the model's expectations.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      total += 3;
      if (pready[i] !== exp_rdy[i]) begin
        bad++;
        $display("FAIL u%0d pready got=%0b want=%0b t=%0t", i, pready[i], exp_rdy[i], $time);
      end
      if (pslverr[i] !== exp_err[i]) begin
        bad++;
        $display("FAIL u%0d pslverr got=%0b want=%0b t=%0t", i, pslverr[i], exp_err[i], $time);
      end
      if (((prdata[i] ^ exp_data[i]) & exp_mask[i]) !== 32'h0) begin
        bad++;
        $display("FAIL u%0d prdata got=%h want=%h mask=%h t=%0t", i, prdata[i], exp_data[i],
                 exp_mask[i], $time);
      end
    end
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic checkint(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic set_idle(input int n);
    exp_rdy[n]  = 1'b0;
    exp_err[n]  = 1'b0;
    exp_data[n] = 32'h0;
    exp_mask[n] = 32'hFFFF_FFFF;
  endtask

  task automatic begin_cycle();
    for (int i = 0; i < NI; i++) begin
      psel[i]    = 1'b0;
      penable[i] = 1'b0;
      set_idle(i);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      begin_cycle();
    end
  endtask

  // One APB transfer; abort_k / rst_k name the access cycle (1-based) in which
  // PSEL is dropped or reset is pulsed, 0 for neither.
  task automatic xfer(input int n, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] sb, input int abort_k, input int rst_k,
                      output int cyc, output logic [31:0] rd, output logic er);
    int         last;
    bit         e;
    bit         cut;
    logic [7:0] idx;
    last = wsf(n) + 1;
    e    = (a >= 12'h400) || (a[1:0] != 2'b00);
    idx  = a[9:2];
    cut  = 1'b0;
    cyc  = 0;
    rd   = 32'h0;
    er   = 1'b0;
    @(posedge clk); #1;
    begin_cycle();
    psel[n] = 1'b1; penable[n] = 1'b0; pwrite[n] = wr;
    paddr[n] = a; pwdata[n] = wd; pstrb[n] = sb;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      begin_cycle();
      if (k != abort_k) begin
        psel[n]    = 1'b1;
        penable[n] = 1'b1;
        paddr[n]   = 12'($urandom);
        pwrite[n]  = 1'($urandom);
      end
      exp_rdy[n] = (k == last);
      exp_err[n] = (k == last) && e;
      if (k == last && !wr && !e) begin
        exp_data[n] = mm[n][idx];
        exp_mask[n] = lane_mask(kn[n][idx]);
      end
      if (k == rst_k) begin
        check32("pre_rst_pready", {31'h0, pready[n]}, {31'h0, k == last});
        #1 rstn[n] = 1'b0;
        set_idle(n);
        #1;
        check32("async_rst_pready", {31'h0, pready[n]}, 32'h0);
        check32("async_rst_pslverr", {31'h0, pslverr[n]}, 32'h0);
        check32("async_rst_prdata", prdata[n], 32'h0);
      end
      @(negedge clk);
      if (pready[n] && cyc == 0) begin
        cyc = k + 1;
        rd  = prdata[n];
        er  = pslverr[n];
      end
      if (k == abort_k || k == rst_k) begin
        cut = 1'b1;
        break;
      end
    end
    if (cut) begin
      @(posedge clk); #1;
      begin_cycle();
      rstn[n] = 1'b1;
    end else if (wr && !e) begin
      for (int b = 0; b < 4; b++) begin
        if (sb[b]) begin
          mm[n][idx][8*b +: 8] = wd[8*b +: 8];
          kn[n][idx][b] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] rd;
    logic        er;
    int          n, r, ab;
    bit          wr;
    logic [11:0] a;

    for (int i = 0; i < NI; i++) begin
      rstn[i] = 1'b0; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = 12'h0; pwdata[i] = 32'h0; pstrb[i] = 4'h0;
      set_idle(i);
      for (int j = 0; j < 256; j++) begin
        mm[i][j] = 32'h0;
        kn[i][j] = 4'h0;
      end
    end
    @(negedge clk);
    check32("reset_pready", {31'h0, pready[0]}, 32'h0);
    check32("reset_prdata", prdata[0], 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rstn[i] = 1'b1;

    // Zero wait states: write then read back, two cycles each.
    xfer(0, 1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 0, 0, cyc, rd, er);
    checkint("ws0_write_cycles", cyc, 2);
    check32("ws0_write_err", {31'h0, er}, 32'h0);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    checkint("ws0_read_cycles", cyc, 2);
    check32("ws0_read_data", rd, 32'hDEAD_BEEF);

    // Three wait states: five cycles per transfer.
    xfer(1, 1'b1, 12'h010, 32'hCAFE_F00D, 4'hF, 0, 0, cyc, rd, er);
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    checkint("ws3_read_cycles", cyc, 5);
    check32("ws3_read_data", rd, 32'hCAFE_F00D);

    // Byte strobes.
    xfer(0, 1'b1, 12'h020, 32'hFFFF_FFFF, 4'hF, 0, 0, cyc, rd, er);
    xfer(0, 1'b1, 12'h020, 32'h1122_3344, 4'b0101, 0, 0, cyc, rd, er);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    check32("strobe_merge", rd, 32'hFF22_FF44);

    // Decode errors.
    xfer(0, 1'b0, 12'h400, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    check32("oor_read_err", {31'h0, er}, 32'h1);
    check32("oor_read_data", rd, 32'h0);
    xfer(0, 1'b1, 12'h3FC, 32'h5A5A_5A5A, 4'hF, 0, 0, cyc, rd, er);
    xfer(0, 1'b1, 12'h401, 32'h0000_0000, 4'hF, 0, 0, cyc, rd, er);
    check32("misaligned_write_err", {31'h0, er}, 32'h1);
    xfer(0, 1'b0, 12'h3FC, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    check32("neighbour_intact", rd, 32'h5A5A_5A5A);

    // Master abort in the first access cycle, then PENABLE without setup.
    xfer(1, 1'b1, 12'h030, 32'h1234_5678, 4'hF, 0, 0, cyc, rd, er);
    xfer(1, 1'b1, 12'h030, 32'hAAAA_AAAA, 4'hF, 1, 0, cyc, rd, er);
    checkint("abort_no_ready", cyc, 0);
    xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    check32("abort_mem_intact", rd, 32'h1234_5678);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      begin_cycle();
      psel[0] = (c != 2); penable[0] = 1'b1;
      psel[1] = (c != 2); penable[1] = 1'b1;
    end
    idle(1);

    // Reset in the second wait cycle of a write loses that write.
    xfer(2, 1'b1, 12'h040, 32'h0BAD_CAFE, 4'hF, 0, 0, cyc, rd, er);
    checkint("ws5_write_cycles", cyc, 7);
    xfer(2, 1'b1, 12'h040, 32'hFFFF_FFFF, 4'hF, 0, 2, cyc, rd, er);
    checkint("rst_write_no_ready", cyc, 0);
    xfer(2, 1'b0, 12'h040, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    check32("rst_write_lost", rd, 32'h0BAD_CAFE);

    // Reset while PREADY is high clears the outputs without a clock edge.
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, 0, 4, cyc, rd, er);
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, 0, 0, cyc, rd, er);
    check32("post_rst_read", rd, 32'hCAFE_F00D);

    // Randomised traffic, including back-to-back transfers and aborts.
    repeat (300) begin
      n  = $urandom_range(0, NI - 1);
      wr = 1'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 6)      a = 12'(($urandom % 16) * 4);
      else if (r < 8) a = 12'(($urandom % 256) * 4);
      else if (r == 8) a = 12'h400 + 12'(($urandom % 256) * 4);
      else begin
        a = 12'($urandom);
        if (a[1:0] == 2'b00) a[0] = 1'b1;
      end
      ab = 0;
      if (wsf(n) > 0 && ($urandom % 8) == 0) ab = $urandom_range(1, wsf(n));
      xfer(n, wr, a, $urandom, 4'($urandom), ab, 0, cyc, rd, er);
      if (ab == 0) checkint("rand_cycles", cyc, wsf(n) + 2);
      if (($urandom % 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-backed slave. It succeeds the fixed-function APB slave in the apb bench and adds byte strobes, configurable wait states, address decode with PSLVERR, and registered, glitch-free response signals. It sits behind the APB master/interconnect as a target for functional verification of master timing, wait-state handling and error responses.

## Interface
- ADDR_WIDTH, 12: PADDR width in bits (byte address).
- DATA_WIDTH, 32: data width; legal values 8, 16, 32.
- DEPTH, 256: number of DATA_WIDTH words; must be ≤ 2**(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- WAIT_STATES, 0: access-phase cycles with PREADY low before completion; range 0–15.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables; ignored on reads.
- PREADY  out  1  transfer completion.
- PRDATA  out  DATA_WIDTH  read data.
- PSLVERR  out  1  transfer error; meaningful only while PREADY=1.

## Operation
- Reset (PRESET=0, async): state IDLE, wait counter 0, PREADY=0, PRDATA=0, PSLVERR=0. Memory contents are not reset and are undefined until written.
- Word index is PADDR >> log2(DATA_WIDTH/8).
- Error condition is evaluated at setup:
  - word index ≥ DEPTH, or
  - PADDR low byte-offset bits ≠ 0 (misaligned).
- FSM with states IDLE and ACCESS:
  - IDLE → ACCESS on a clock edge with PSEL=1, PENABLE=0 (setup phase). That edge captures PWRITE, word index, error flag and read data (mem[index], or 0 on error), and loads the counter with WAIT_STATES.
  - ACCESS, PSEL=1, PENABLE=1, counter>0: decrement; stay in ACCESS.
  - ACCESS, PSEL=1, PENABLE=1, counter=0: transfer completes this cycle; next state IDLE.
  - ACCESS, PSEL=0 (master abort): next state IDLE, no memory update.
  - IDLE with PENABLE=1 but no preceding setup: ignored; stay IDLE with PREADY=0.
- Output decode is a function of registered state only:
  - PREADY=1 iff state=ACCESS and counter=0.
  - PSLVERR = PREADY & error flag.
  - PRDATA = captured read data iff PREADY & !write, else 0.
- Write commit happens at the completion edge when there is no error:
  - for each lane i with PSTRB[i]=1, mem[index] byte i ← PWDATA byte i (PWDATA/PSTRB sampled at that edge);
  - lanes with PSTRB[i]=0 are unchanged;
  - PSTRB=0 is a legal no-op write.
- An erroring write does not modify memory. An erroring read returns PRDATA=0 with PSLVERR=1.
- PADDR/PWRITE changes during ACCESS are ignored; the values captured at setup are used.

## Timing
- Latency:
  - With WAIT_STATES=N, PREADY rises in access-phase cycle N+1.
  - A full transfer takes N+2 cycles (setup + N waits + completion).
  - With N=0: setup cycle, then PREADY=1 in the first access cycle.
- Back-to-back transfers:
  - A new setup can occur in the cycle immediately after completion (IDLE accepts it).
  - A read setup immediately following a write completion to the same address returns the new data, because the commit edge precedes the read's capture edge.
- PREADY, PSLVERR and PRDATA are combinational decodes of flops only, with no combinational paths from inputs.
- Reset asserted mid-transfer: outputs clear immediately (async). Any write not yet at its completion edge is lost.

## Test plan
- Reset, DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to 0x010, PSTRB=4'hF, then read 0x010 → PREADY high in first access cycle both times, PRDATA=0xDEADBEEF, PSLVERR=0, 2 cycles per transfer.
- WAIT_STATES=3: read at 0x010 → PREADY low for 3 access cycles, high on the 4th with data. Master holding PENABLE until then completes in 5 cycles.
- Byte strobes: write 0xFFFFFFFF to 0x020, then write 0x11223344 with PSTRB=4'b0101, then read → 0xFF22FF44.
- Errors, DEPTH=256: read 0x400 → PSLVERR=1, PRDATA=0. Write 0x401 (misaligned) → PSLVERR=1, and a later read of 0x400's in-range neighbour 0x3FC is unchanged.
- Abort and illegal input: setup a write to 0x030, drop PSEL in the access cycle → no PREADY, memory unchanged. PENABLE=1 without setup → PREADY stays 0.
- Reset mid-transfer: WAIT_STATES=5, assert PRESET=0 during the 2nd wait cycle of a write to 0x040 → PREADY/PSLVERR/PRDATA go 0 asynchronously. After release, a read of 0x040 shows the prior contents.
